// File: rtl/implication_queue.sv
// Implication queue for the SAT BCP path: drops duplicate implications, flags
// conflicting ones, and buffers the rest in a FIFO for the trail updater.
module implication_queue #(
    parameter int VAR_W    = 9,
    parameter int NUM_VARS = 512,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push_valid,
    input  logic [VAR_W-1:0] push_var,
    input  logic             push_value,
    output logic             push_ready,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [VAR_W-1:0] pop_var,
    output logic             pop_value,
    output logic             conflict,
    output logic [VAR_W-1:0] conflict_var,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {RUN, CONFLICT} state_t;

    state_t                state;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [NUM_VARS-1:0]   pend_v;
    logic [NUM_VARS-1:0]   pend_val;
    logic [VAR_W-1:0]      fifo_var [DEPTH];
    logic                  fifo_val [DEPTH];

    logic push_fire;
    logic pop_fire;
    logic enq;
    logic clash;

    assign push_ready = (state == RUN) && (count < CNT_W'(DEPTH));
    assign pop_valid  = (state == RUN) && (count != '0);
    assign pop_var    = (count != '0) ? fifo_var[head] : '0;
    assign pop_value  = (count != '0) ? fifo_val[head] : 1'b0;

    assign push_fire = push_valid && push_ready;
    assign pop_fire  = pop_valid && pop_ready;
    // Classification uses the pre-edge pending table, so a same-cycle pop of
    // the same variable still makes the push a duplicate or a conflict.
    assign enq   = push_fire && !pend_v[push_var] && !flush;
    assign clash = push_fire && pend_v[push_var] && (pend_val[push_var] != push_value) && !flush;

    // NOTE: storage arrays carry no reset; validity comes from pend_v and count,
    // which keeps the large tables as plain flops without reset routing.
    always_ff @(posedge clock) begin
        if (enq) begin
            fifo_var[tail]     <= push_var;
            fifo_val[tail]     <= push_value;
            pend_val[push_var] <= push_value;
        end
    end

    // NOTE: all state uses non-blocking assignments so every read above sees
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            pend_v       <= '0;
            conflict     <= 1'b0;
            conflict_var <= '0;
        end else if (flush) begin
            state        <= RUN;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            pend_v       <= '0;
            conflict     <= 1'b0;
            conflict_var <= '0;
        end else begin
            // A popped variable is always pending, so it can never collide with
            // an enqueue (which requires the variable to be not pending).
            if (pop_fire) begin
                head            <= head + 1'b1;
                pend_v[pop_var] <= 1'b0;
            end
            if (enq) begin
                tail             <= tail + 1'b1;
                pend_v[push_var] <= 1'b1;
            end
            unique case ({enq, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (clash) begin
                state        <= CONFLICT;
                conflict     <= 1'b1;
                conflict_var <= push_var;
            end
        end
    end

endmodule

// File: tb/tb_implication_queue.sv
// Self-checking bench for implication_queue: directed scenarios followed by a
// randomized run, all compared against a queue-based behavioural model.
module tb_implication_queue;

    localparam int VAR_W = 9;
    localparam int NUM_VARS = 512;
    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             push_valid = 1'b0;
    logic [VAR_W-1:0] push_var = '0;
    logic             push_value = 1'b0;
    logic             push_ready;
    logic             pop_valid;
    logic             pop_ready = 1'b0;
    logic [VAR_W-1:0] pop_var;
    logic             pop_value;
    logic             conflict;
    logic [VAR_W-1:0] conflict_var;
    logic [CNT_W-1:0] count;

    implication_queue #(
        .VAR_W(VAR_W), .NUM_VARS(NUM_VARS), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .push_valid(push_valid), .push_var(push_var), .push_value(push_value),
        .push_ready(push_ready), .pop_valid(pop_valid), .pop_ready(pop_ready),
        .pop_var(pop_var), .pop_value(pop_value), .conflict(conflict),
        .conflict_var(conflict_var), .count(count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model: the queue holds {var, value} in arrival order.
    typedef struct { int v; bit val; } impl_t;
    impl_t m_q[$];
    bit    m_pend[NUM_VARS];
    bit    m_pval[NUM_VARS];
    bit    m_conf;
    int    m_cvar;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        for (int i = 0; i < NUM_VARS; i++) m_pend[i] = 1'b0;
        m_conf = 1'b0;
        m_cvar = 0;
    endtask

    task automatic model_step(input bit pv, input int v, input bit val, input bit pr, input bit fl);
        bit can_push, can_pop, do_enq;
        if (fl) begin
            model_clear();
            return;
        end
        can_push = !m_conf && m_q.size() < DEPTH;
        can_pop  = !m_conf && m_q.size() > 0;
        do_enq = 1'b0;
        if (pv && can_push) begin
            if (!m_pend[v]) do_enq = 1'b1;
            else if (m_pval[v] != val) begin
                m_conf = 1'b1;
                m_cvar = v;
            end
        end
        if (pr && can_pop) begin
            m_pend[m_q[0].v] = 1'b0;
            void'(m_q.pop_front());
        end
        if (do_enq) begin
            m_q.push_back('{v: v, val: val});
            m_pend[v] = 1'b1;
            m_pval[v] = val;
        end
    endtask

    task automatic compare_all(input string tag);
        int exp_pv;
        exp_pv = (!m_conf && m_q.size() > 0) ? 1 : 0;
        check({tag, ".count"}, int'(count), m_q.size());
        check({tag, ".push_ready"}, int'(push_ready), (!m_conf && m_q.size() < DEPTH) ? 1 : 0);
        check({tag, ".pop_valid"}, int'(pop_valid), exp_pv);
        check({tag, ".conflict"}, int'(conflict), int'(m_conf));
        check({tag, ".conflict_var"}, int'(conflict_var), m_cvar);
        if (exp_pv == 1) begin
            check({tag, ".pop_var"}, int'(pop_var), m_q[0].v);
            check({tag, ".pop_value"}, int'(pop_value), int'(m_q[0].val));
        end
    endtask

    // Drive one cycle of stimulus on the falling edge, check on the next one.
    task automatic step(input string tag, input bit pv, input int v, input bit val,
                        input bit pr, input bit fl);
        push_valid = pv;
        push_var   = VAR_W'(v);
        push_value = val;
        pop_ready  = pr;
        flush      = fl;
        model_step(pv, v, val, pr, fl);
        @(posedge clock);
        @(negedge clock);
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
        compare_all(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".count"}, int'(count), 0);
        check({tag, ".pop_valid"}, int'(pop_valid), 0);
        check({tag, ".pop_var"}, int'(pop_var), 0);
        check({tag, ".pop_value"}, int'(pop_value), 0);
        check({tag, ".conflict"}, int'(conflict), 0);
        check({tag, ".conflict_var"}, int'(conflict_var), 0);
        check({tag, ".push_ready"}, int'(push_ready), 1);
    endtask

    initial begin
        model_clear();
        #12;
        check_reset_values("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        compare_all("post_reset");

        // Basic ordering
        step("push5", 1, 5, 1, 0, 0);
        step("push9", 1, 9, 0, 0, 0);
        step("pop5", 0, 0, 0, 1, 0);
        step("pop9", 0, 0, 0, 1, 0);

        // Duplicate drop, then re-enqueue after the pop
        step("dup_a", 1, 17, 1, 0, 0);
        step("dup_b", 1, 17, 1, 0, 0);
        step("dup_pop", 0, 0, 0, 1, 0);
        step("dup_idle", 0, 0, 0, 1, 0);
        step("dup_again", 1, 17, 1, 0, 0);
        step("dup_drain", 0, 0, 0, 1, 0);

        // Conflict is sticky and holds the FIFO until flush
        step("cf_a", 1, 42, 0, 0, 0);
        step("cf_b", 1, 42, 1, 0, 0);
        step("cf_hold", 1, 43, 1, 1, 0);
        step("cf_flush", 0, 0, 0, 0, 1);

        // Full boundary: the push with a simultaneous pop is still refused
        for (int i = 0; i < DEPTH; i++) step("fill", 1, 200 + i, i[0], 0, 0);
        step("full_refuse", 1, 250, 1, 0, 0);
        step("full_pushpop", 1, 100, 1, 1, 0);
        for (int i = 0; i < DEPTH; i++) step("drain", 0, 0, 0, 1, 0);

        // Same-cycle hazard on the head variable
        step("hz_push", 1, 7, 1, 0, 0);
        step("hz_dup_pop", 1, 7, 1, 1, 0);
        step("hz_reenq", 1, 7, 1, 0, 0);
        step("hz_conf_pop", 1, 7, 0, 1, 0);
        step("hz_flush", 0, 0, 0, 0, 1);

        // Flush wins over a simultaneous push and pop
        step("fl_pre", 1, 30, 1, 0, 0);
        step("fl_prio", 1, 31, 0, 1, 1);

        // Asynchronous reset mid-cycle
        step("ar_a", 1, 1, 1, 0, 0);
        step("ar_b", 1, 2, 0, 0, 0);
        step("ar_c", 1, 3, 1, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_clear();
        @(negedge clock);
        reset_n = 1'b1;
        step("ar_after", 1, 3, 0, 0, 0);

        // Randomized traffic over a small variable range to provoke hits
        for (int n = 0; n < 600; n++) begin
            bit fl;
            fl = ($urandom_range(0, 59) == 0) || (m_conf && $urandom_range(0, 3) == 0);
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 23),
                 1'($urandom), $urandom_range(0, 9) < 4, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
